// File: rtl/std_bypass_arbiter_if.sv
// Bus bundle between the cache-controller requesters, the bypass arbiter and the
// downstream bypass AXI adapter. The arbiter uses the slave modport; the environment uses master.
interface std_bypass_arbiter_if #(
    parameter int NR_PORTS = 4,
    parameter int ADDR_W   = 64,
    parameter int DATA_W   = 64,
    parameter int ID_W     = 4
);
    // Requester side
    logic [NR_PORTS-1:0]          req_i;
    logic [NR_PORTS*ADDR_W-1:0]   addr_i;
    logic [NR_PORTS*DATA_W-1:0]   wdata_i;
    logic [NR_PORTS-1:0]          we_i;
    logic [NR_PORTS*DATA_W/8-1:0] be_i;
    logic [NR_PORTS*2-1:0]        size_i;
    logic [NR_PORTS-1:0]          gnt_o;
    logic [NR_PORTS-1:0]          valid_o;
    logic [DATA_W-1:0]            rdata_o;

    // Downstream side
    logic                         req_o;
    logic [ADDR_W-1:0]            addr_o;
    logic [DATA_W-1:0]            wdata_o;
    logic                         we_o;
    logic [DATA_W/8-1:0]          be_o;
    logic [1:0]                   size_o;
    logic [ID_W-1:0]              id_o;
    logic                         gnt_i;
    logic                         valid_i;
    logic [DATA_W-1:0]            rdata_i;

    modport master (
        output req_i, addr_i, wdata_i, we_i, be_i, size_i, gnt_i, valid_i, rdata_i,
        input  gnt_o, valid_o, rdata_o, req_o, addr_o, wdata_o, we_o, be_o, size_o, id_o
    );

    modport slave (
        input  req_i, addr_i, wdata_i, we_i, be_i, size_i, gnt_i, valid_i, rdata_i,
        output gnt_o, valid_o, rdata_o, req_o, addr_o, wdata_o, we_o, be_o, size_o, id_o
    );
endinterface

// File: rtl/std_bypass_arbiter.sv
// Round-robin arbiter for the uncached bypass path, one transaction in flight at a time.
// Define STD_BYPASS_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead.
module std_bypass_arbiter #(
    parameter int NR_PORTS = 4,
    parameter int ADDR_W   = 64,
    parameter int DATA_W   = 64,
    parameter int ID_W     = 4
) (
    input logic                clk_i,
    input logic                rst_ni,
    std_bypass_arbiter_if.slave bus
);

    localparam int IDX_W = $clog2(NR_PORTS);
    localparam int BE_W  = DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT
    } state_t;

    state_t              state;
    logic [IDX_W-1:0]    rr_ptr;
    logic [IDX_W-1:0]    winner;
    logic                found;
    int                  cand;

    logic                req_p1;
    logic [IDX_W-1:0]    idx_p1;
    logic [ADDR_W-1:0]   addr_p1;
    logic [DATA_W-1:0]   wdata_p1;
    logic                we_p1;
    logic [BE_W-1:0]     be_p1;
    logic [1:0]          size_p1;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
        if (int'(v) == NR_PORTS - 1) return '0;
        return v + 1'b1;
    endfunction

    // Scan from rr_ptr upward with wrap; first set request wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = 0;
        for (int i = 0; i < NR_PORTS; i++) begin
            cand = int'(rr_ptr) + i;
            if (cand >= NR_PORTS) cand = cand - NR_PORTS;
            if (!found && bus.req_i[cand]) begin
                found  = 1'b1;
                winner = IDX_W'(cand);
            end
        end
    end

    // Grant and response strobes are combinational so the requester sees them in the same cycle.
    always_comb begin
        bus.gnt_o   = '0;
        bus.valid_o = '0;
        if (state == ST_IDLE && found) bus.gnt_o[winner] = 1'b1;
        if (bus.valid_i && (state == ST_WAIT || (state == ST_REQ && bus.gnt_i)))
            bus.valid_o[idx_p1] = 1'b1;
    end

`ifdef STD_BYPASS_ARB_FIXED_PRIO_EN
    assign rr_ptr = '0;
`else
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr <= '0;
        end else if (state == ST_IDLE && found) begin
            rr_ptr <= wrap_inc(winner);
        end
    end
`endif

    // p0 -> p1: capture winner payload, then hold it until the downstream grant.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= ST_IDLE;
            req_p1   <= 1'b0;
            idx_p1   <= '0;
            addr_p1  <= '0;
            wdata_p1 <= '0;
            we_p1    <= 1'b0;
            be_p1    <= '0;
            size_p1  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        idx_p1   <= winner;
                        addr_p1  <= bus.addr_i[int'(winner)*ADDR_W +: ADDR_W];
                        wdata_p1 <= bus.wdata_i[int'(winner)*DATA_W +: DATA_W];
                        we_p1    <= bus.we_i[winner];
                        be_p1    <= bus.be_i[int'(winner)*BE_W +: BE_W];
                        size_p1  <= bus.size_i[int'(winner)*2 +: 2];
                        req_p1   <= 1'b1;
                        state    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (bus.gnt_i) begin
                        req_p1 <= 1'b0;
                        state  <= bus.valid_i ? ST_IDLE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.valid_i) state <= ST_IDLE;
                end
                default: begin
                    req_p1 <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_o   = req_p1;
    assign bus.addr_o  = addr_p1;
    assign bus.wdata_o = wdata_p1;
    assign bus.we_o    = we_p1;
    assign bus.be_o    = be_p1;
    assign bus.size_o  = size_p1;
    assign bus.rdata_o = bus.rdata_i;

    always_comb begin
        bus.id_o              = '0;
        bus.id_o[IDX_W-1:0]   = idx_p1;
    end

endmodule
